// File: rtl/dynamic_lighting_scheduler.sv
// Multiplexed common-anode 7-segment scheduler: per-digit time slices with a
// leading blank window, brightness-limited on time and per-frame data latching.
module dynamic_lighting_scheduler #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SLOT_TICKS  = 16,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CE,
  input  logic                    EN,
  input  logic [4*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   DIG_EN,
  input  logic [3:0]              BRIGHT,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    FRAME_DONE
);

  localparam int unsigned DW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW     = $clog2(SLOT_TICKS + 1);
  localparam int unsigned ON_MAX = SLOT_TICKS - BLANK_TICKS;

  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] SLOT_END   = CW'(SLOT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

  state_t                  state;
  logic [DW-1:0]           digit;
  logic [CW-1:0]           count;
  logic [CW-1:0]           on_end;
  logic [4*NUM_DIGITS-1:0] data_lat;
  logic [NUM_DIGITS-1:0]   dp_lat;
  logic [NUM_DIGITS-1:0]   en_lat;

  logic [CW-1:0]           bright_eff_c;
  logic [3:0]              nibble_c;
  logic [6:0]              seg_c;
  logic [NUM_DIGITS-1:0]   an_on_c;
  logic                    slot_end_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Slot arithmetic and the lit pattern for the current digit.
  always_comb begin
    bright_eff_c = (32'(BRIGHT) > ON_MAX) ? CW'(ON_MAX) : CW'(BRIGHT);
    nibble_c     = data_lat[{digit, 2'b00} +: 4];
    seg_c        = seg_decode(nibble_c);
    an_on_c      = en_lat[digit] ? ~(NUM_DIGITS'(1) << digit) : '1;
    slot_end_c   = ((state == OFF) && (count == SLOT_END)) ||
                   ((state == ON) && (count == on_end) && (on_end == SLOT_END));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      digit      <= '0;
      count      <= '0;
      on_end     <= '0;
      data_lat   <= '0;
      dp_lat     <= '0;
      en_lat     <= '0;
      AN         <= '1;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (!EN) begin
        state <= IDLE;
        digit <= '0;
        count <= '0;
        AN    <= '1;
        SEG   <= 7'h7F;
        DP    <= 1'b1;
      end else if (CE) begin
        // Dark unless this tick enters or continues the on window.
        AN    <= '1;
        SEG   <= 7'h7F;
        DP    <= 1'b1;
        count <= count + CW'(1);
        if (slot_end_c) begin
          state <= BLANK;
          count <= '0;
          if (digit == LAST_DIGIT) begin
            digit      <= '0;
            FRAME_DONE <= 1'b1;
            data_lat   <= DATA;
            dp_lat     <= DP_IN;
            en_lat     <= DIG_EN;
          end else begin
            digit <= digit + DW'(1);
          end
        end else begin
          case (state)
            IDLE: begin
              state    <= BLANK;
              digit    <= '0;
              count    <= '0;
              data_lat <= DATA;
              dp_lat   <= DP_IN;
              en_lat   <= DIG_EN;
            end
            BLANK: begin
              if (count == BLANK_END) begin
                if (bright_eff_c == '0) begin
                  state <= OFF;
                end else begin
                  state  <= ON;
                  on_end <= BLANK_END + bright_eff_c;
                  AN     <= an_on_c;
                  SEG    <= seg_c;
                  DP     <= ~dp_lat[digit];
                end
              end
            end
            ON: begin
              if (count == on_end) begin
                state <= OFF;
              end else begin
                AN  <= an_on_c;
                SEG <= seg_c;
                DP  <= ~dp_lat[digit];
              end
            end
            OFF:     state <= OFF;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/dynamic_lighting_scheduler.md
Name: dynamic_lighting_scheduler

Overview:
Sequences a multiplexed 4-digit common-anode 7-segment display.
- Consumes the one-cycle clock-enable tick from the display-rate divider. Its CE_OUT connects to CE here.
- Time-slices the digits, with a ghost-suppression blank window and a brightness duty control.
- Latches display data once per frame so a digit never shows half-updated values.
- Sits between the ALU result registers and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; AN and DATA scale with it.
- SLOT_TICKS, 16, CE ticks per digit slot.
- BLANK_TICKS, 2, CE ticks at the start of each slot with all anodes off. Must be < SLOT_TICKS.

Ports:
- CLK  input  1  system clock (40 MHz board clock).
- RST_N  input  1  asynchronous active-low reset.
- CE  input  1  one-CLK tick from the divider; all sequencing advances only on CLK edges with CE=1.
- EN  input  1  display enable; 0 forces dark and idle.
- DATA  input  4*NUM_DIGITS  hex nibble per digit; digit 0 = bits [3:0].
- DP_IN  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- DIG_EN  input  NUM_DIGITS  per-digit enable, 0 = digit slot stays dark (leading-zero blanking).
- BRIGHT  input  4  on-ticks per slot, 0..15, clamped to SLOT_TICKS-BLANK_TICKS.
- AN  output  NUM_DIGITS  anode select, active-low, registered.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- DP  output  1  decimal point, active-low, registered.
- FRAME_DONE  output  1  one-CLK pulse when the last digit slot ends.

Behaviour:
Reset (RST_N=0, asynchronous):
- AN=all 1, SEG=7'h7F, DP=1, FRAME_DONE=0.
- State=IDLE, digit index=0, tick count=0, latched data cleared.

States:
- IDLE: outputs dark.
  - EN=1 and CE=1 -> BLANK, digit 0, count 0, and latch DATA/DP_IN/DIG_EN into the frame registers.
- BLANK: outputs dark. Count increments per CE.
  - Count reaches BLANK_TICKS-1 on CE -> ON, or OFF if the effective on-ticks are 0.
- ON: AN drives the low bit of the current digit only if its latched DIG_EN=1. SEG/DP come from the latched nibble and DP.
  - ON lasts exactly min(BRIGHT,SLOT_TICKS-BLANK_TICKS) CE ticks, then OFF.
  - BRIGHT is sampled at BLANK->ON entry; changes mid-slot take effect next slot.
- OFF: outputs dark until the slot total reaches SLOT_TICKS ticks.
  - Then advance to the next digit and return to BLANK.
  - If the digit was NUM_DIGITS-1: FRAME_DONE=1 for that CLK, digit wraps to 0, and the frame registers re-latch in the same cycle.
  - If on-ticks = SLOT_TICKS-BLANK_TICKS, OFF lasts 0 ticks: ON goes directly to the slot-end transition.

Timing and latency:
- Outputs update on the CLK edge where CE=1 causes the transition (one register stage).
- No output changes on CLK edges with CE=0.

EN handling:
- EN=0 in any state: the next CLK edge (CE-independent) -> IDLE, outputs dark, digit=0, FRAME_DONE=0.
- Mid-frame disable abandons the frame; no FRAME_DONE pulse.

Data handling:
- DATA changes mid-frame are invisible until the next frame latch.

Segment decode (active-low, g..a):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12
- 6=02, 7=78, 8=00, 9=10
- A=08, b=03, C=46, d=21, E=06, F=0E

Invariants:
- At most one AN bit is low at any time.
- AN is never low during BLANK.

Frame length: NUM_DIGITS*SLOT_TICKS CE ticks (64 with defaults).

Test Plan:
- Reset mid-ON with AN=1110 -> AN=1111, SEG=7F, DP=1 immediately, with no CLK edge needed. After release with EN=1, the first CE enters BLANK digit 0.
- DATA=16'h1A3F, DP_IN=0100, DIG_EN=1111, BRIGHT=15, CE every 4 CLK -> per frame:
  - AN cycles 1110,1101,1011,0111, each low for 14 CE ticks after 2 dark ticks.
  - SEG 0E,21? no: digit0=F->0E, digit1=3->30, digit2=A->08, digit3=1->79; DP low only on digit 2.
  - FRAME_DONE pulses once per 64 CE ticks.
- BRIGHT=3 -> AN low exactly 3 CE ticks per slot, dark 13. BRIGHT=0 -> AN stays 1111 all frame while FRAME_DONE still pulses every 64 ticks.
- DIG_EN=0011 -> AN never drives digits 2/3 low; slot timing unchanged (frame still 64 ticks).
- DATA changed from 1111 to 2222 during digit 1's ON -> digits 1-3 still show 1 (79). The new value appears only from the next frame's digit 0.
- EN dropped during digit 2 -> next CLK AN=1111, no FRAME_DONE. EN re-raised -> restart at digit 0 with a fresh latch.
